bs8_barrel_shifter: RTL and testbench
=====================================

// Module: bs8_barrel_shifter
// PURPOSE
//   8-bit logarithmic barrel shifter with a registered output.
//   Shifts data word a by 0..7 positions, left or right, selected per cycle.
//   Used as a shift/alignment unit inside datapaths.
//   One clock cycle of latency, with a valid flag carried alongside the data.
// PARAMETERS
//   WIDTH    8   data width; only 8 is supported (structure is 3 mux stages)
//   SHAMT_W  3   shift-amount width, equal to log2(WIDTH)
// PORTS
//   clk        in   1        clock; all state updates on the rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        a/s/d are valid this cycle
//   a          in   WIDTH    data to shift
//   s          in   SHAMT_W  shift amount, 0..7
//   d          in   1        direction: 0 = left (toward MSB), 1 = right (toward LSB)
//   rot        in   1        present only when BS8_ROTATE_EN is defined; 1 = rotate
//   out        out  WIDTH    shifted result, registered
//   out_valid  out  1        out holds a result for the in_valid of the previous cycle
// BEHAVIOUR
// - Reset: synchronous, active-high. While rst=1 at a rising edge: out<=8'h00, out_valid<=0.
//   - rst has priority over in_valid.
//   - A request presented in the same cycle as rst is dropped.
// - Combinational core: three cascaded stages, shifting by 1, 2 and 4 under s[0], s[1] and s[2].
//   - Each stage uses the direction d.
//   - No multiply or `<<` on a variable amount is permitted.
// - Logical shift (default):
//   - d=0: out = a << s, vacated LSBs filled with 0.
//   - d=1: out = a >> s, vacated MSBs filled with 0.
// - Shift amount s=0 passes a through unchanged, in both directions.
// - s=7 leaves one surviving bit: a[0] at bit 7 (left), or a[7] at bit 0 (right).
// - Timing, at each rising edge with rst=0:
//   - out_valid <= in_valid.
//   - If in_valid=1, out <= shift(a,s,d).
//   - If in_valid=0, out holds its previous value.
// - Latency is exactly 1 cycle. Throughput is one result per cycle; back-to-back requests are allowed.
// - No backpressure and no internal state beyond the output registers.
// - Inputs are sampled only at the clock edge. Changes to a/s/d between edges have no effect.
// CONFIGURATION
// - Macro BS8_ROTATE_EN.
// - When defined:
//   - Input port rot is added.
//   - rot=1 selects rotation: bits shifted out re-enter at the opposite end.
//     - d=0: out = {a,a} >> (8-s) (rotate left).
//     - d=1: out = {a,a} >> s (rotate right).
//   - rot=0 gives the logical shift described above.
// - When undefined: port rot does not exist, and the block is logical shift only.
// - Latency and reset are identical in both builds.
// TESTING
// - Reset: hold rst=1 for 2 cycles with in_valid=1 -> out=8'h00, out_valid=0.
//   - Release rst -> first result appears 1 cycle after the first in_valid.
// - Left sweep: a=8'hFF, d=0, s=0..7 on consecutive cycles ->
//   - out = FF,FE,FC,F8,F0,E0,C0,80.
//   - Each value appears one cycle after its request; out_valid=1 throughout.
// - Right sweep: a=8'hFF, d=1, s=0..7 ->
//   - out = FF,7F,3F,1F,0F,07,03,01.
// - Pattern check: a=8'hA5.
//   - s=3, d=0 -> 8'h28.
//   - s=3, d=1 -> 8'h14.
//   - s=7, d=1 -> 8'h01.
// - Hold and reset mid-stream:
//   - in_valid=0 for 3 cycles after a result -> out unchanged, out_valid=0.
//   - Assert rst while in_valid=1 -> next cycle out=8'h00, out_valid=0.
// - BS8_ROTATE_EN build, with rot=1 and a=8'h81:
//   - s=1, d=0 -> 8'h03.
//   - s=1, d=1 -> 8'hC0.
//   - s=0 -> 8'h81.
//   - With rot=0, repeat the left sweep -> same results as the logical build.

Source files
------------

// File: rtl/bs8_barrel_shifter.sv
// bs8_barrel_shifter
//   8-bit logarithmic barrel shifter with a registered output and a valid
//   flag carried alongside the data (one cycle of latency, one result per
//   cycle, no backpressure).
//
//   The combinational core is three cascaded mux stages that shift by 1, 2
//   and 4 positions under s[0], s[1] and s[2]. Every stage shifts in the
//   same direction d. In the logical mode the vacated positions fill with
//   zero. In the rotate mode they take the bits that fall off the other end.
//
// Configuration
//   BS8_ROTATE_EN : when defined, adds input rot (1 = rotate, 0 = logical).
//                   When undefined, the block is a logical shifter only.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous, active-high reset (beats in_valid)
//   in_valid   in   1        a/s/d (and rot) are valid this cycle
//   a          in   WIDTH    data to shift
//   s          in   SHAMT_W  shift amount 0..7
//   d          in   1        0 = left (toward MSB), 1 = right (toward LSB)
//   rot        in   1        rotate select (BS8_ROTATE_EN builds only)
//   out        out  WIDTH    registered result
//   out_valid  out  1        out holds the result of last cycle's request

module bs8_barrel_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] s,
  input  logic               d,
`ifdef BS8_ROTATE_EN
  input  logic               rot,
`endif
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  // Single internal rotate select, so the mux stages are the same in both
  // builds. In the logical-only build it is tied low and the fill terms
  // reduce to constant zero.
  logic rot_en;
`ifdef BS8_ROTATE_EN
  assign rot_en = rot;
`else
  assign rot_en = 1'b0;
`endif

  logic [WIDTH-1:0] st1;
  logic [WIDTH-1:0] st2;
  logic [WIDTH-1:0] st4;

  // Each stage works the same way. For a right shift the fill goes into the
  // top n bits and comes from the n bits that fall off the bottom. For a
  // left shift the fill goes into the bottom n bits and comes from the n
  // bits that fall off the top. With rot_en low the fill is zero.
  always_comb begin
    // NOTE: each stage output is assigned on every path, with the pass-through
    // value first, so no latch is inferred when the stage is bypassed.
    st1 = a;
    if (s[0]) begin
      if (d) st1 = {a[0] & rot_en, a[WIDTH-1:1]};
      else   st1 = {a[WIDTH-2:0], a[WIDTH-1] & rot_en};
    end

    st2 = st1;
    if (s[1]) begin
      if (d) st2 = {st1[1:0] & {2{rot_en}}, st1[WIDTH-1:2]};
      else   st2 = {st1[WIDTH-3:0], st1[WIDTH-1:WIDTH-2] & {2{rot_en}}};
    end

    st4 = st2;
    if (s[2]) begin
      if (d) st4 = {st2[3:0] & {4{rot_en}}, st2[WIDTH-1:4]};
      else   st4 = {st2[WIDTH-5:0], st2[WIDTH-1:WIDTH-4] & {4{rot_en}}};
    end
  end

  // Output register. Reset takes priority, so a request presented during
  // reset is dropped. When in_valid is low, out keeps its last result.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every register
    // samples its inputs from before the edge, whatever the statement order.
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= st4;
    end
  end

endmodule

// File: tb/tb_bs8_barrel_shifter.sv
// tb_bs8_barrel_shifter
//   Scoreboard bench for bs8_barrel_shifter. The driver pushes a hand-computed
//   result into a queue for each accepted request. A monitor on the falling
//   edge pops an entry whenever out_valid is high, then compares the data and
//   the one-cycle latency. Reset and hold behaviour are checked directly by
//   the driver. Define BS8_ROTATE_EN to exercise the rotate build.

module tb_bs8_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic [7:0] a = 8'hFF;
  logic [2:0] s = 3'd0;
  logic       d = 1'b0;
  logic       rot = 1'b0;
  logic [7:0] out;
  logic       out_valid;

  always #5 clk = ~clk;

  bs8_barrel_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .s         (s),
    .d         (d),
`ifdef BS8_ROTATE_EN
    .rot       (rot),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: each valid output consumes the oldest expected result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %h with no request outstanding", out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", out, e.data);
        check("latency", 8'(cyc - e.cyc), 8'd1);
      end
    end
  end

  // Presents one request on the next cycle and records its expected result.
  task automatic issue(input logic [7:0] av, input logic [2:0] sv, input logic dv,
                       input logic rv, input logic [7:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    a        = av;
    s        = sv;
    d        = dv;
    rot      = rv;
    e.data   = expv;
    e.cyc    = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [7:0] left_exp  [8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  logic [7:0] right_exp [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

  initial begin
    // Reset held for two edges with a request present: it must be dropped.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", out, 8'h00);
    check("reset_valid", {7'd0, out_valid}, 8'h00);

    // Release reset with nothing requested, then run the sweeps back to back.
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) issue(8'hFF, 3'(i), 1'b0, 1'b0, left_exp[i]);
    for (int i = 0; i < 8; i++) issue(8'hFF, 3'(i), 1'b1, 1'b0, right_exp[i]);

    // Pattern checks on 8'hA5, including the s=7 single-surviving-bit cases.
    issue(8'hA5, 3'd3, 1'b0, 1'b0, 8'h28);
    issue(8'hA5, 3'd3, 1'b1, 1'b0, 8'h14);
    issue(8'hA5, 3'd7, 1'b0, 1'b0, 8'h80);
    issue(8'hA5, 3'd0, 1'b1, 1'b0, 8'hA5);
    issue(8'hA5, 3'd7, 1'b1, 1'b0, 8'h01);

    // Hold: the first idle cycle still shows the last result. The next three
    // idle cycles must hold 8'h01 with out_valid low.
    for (int i = 0; i < 4; i++) begin
      idle();
      @(negedge clk);
      if (i > 0) begin
        check("hold_out", out, 8'h01);
        check("hold_valid", {7'd0, out_valid}, 8'h00);
      end
    end

`ifdef BS8_ROTATE_EN
    issue(8'h81, 3'd1, 1'b0, 1'b1, 8'h03);
    issue(8'h81, 3'd1, 1'b1, 1'b1, 8'hC0);
    issue(8'h81, 3'd0, 1'b0, 1'b1, 8'h81);
    issue(8'h81, 3'd0, 1'b1, 1'b1, 8'h81);
    issue(8'hA5, 3'd3, 1'b0, 1'b1, 8'h2D);
    issue(8'hA5, 3'd3, 1'b1, 1'b1, 8'hB4);
    for (int i = 0; i < 8; i++) issue(8'hFF, 3'(i), 1'b0, 1'b0, left_exp[i]);
`endif

    // Reset mid-stream while a request is presented: the request is dropped.
    issue(8'h3C, 3'd2, 1'b0, 1'b0, 8'hF0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'h5A;
    s        = 3'd1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out", out, 8'h00);
    check("midrst_valid", {7'd0, out_valid}, 8'h00);

    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
